// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit and the ALU decode.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] MULT_OP  = 5'b00110;
  localparam logic [4:0] MULTU_OP = 5'b00111;
  localparam logic [4:0] DIV_OP   = 5'b01000;
  localparam logic [4:0] DIVU_OP  = 5'b01001;
  localparam logic [4:0] MTHI_OP  = 5'b10010;
  localparam logic [4:0] MTLO_OP  = 5'b10011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: one shift-add (mode=0) or restoring-subtract (mode=1) step per cycle.
// Multiply: acc holds {partial product, remaining multiplier}, opnd holds the multiplicand.
// Divide:   acc[XLEN-1:0] shifts dividend out / quotient in, opnd holds the divisor.
module muldiv_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              mode,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem,
  output logic              last
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   rem_q;
  logic [5:0]        cnt_q;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     part;
  logic [XLEN:0]     diff;

  // Step arithmetic: carry-extended add for multiply, 33-bit partial remainder trial subtract for divide.
  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    part = {rem_q, acc_q[XLEN-1]};
    diff = part - {1'b0, opnd_q};
  end

  // Operand load and per-cycle iteration.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      cnt_q <= '0;
      rem_q <= '0;
      if (mode) begin
        acc_q  <= {{XLEN{1'b0}}, a};
        opnd_q <= b;
      end else begin
        acc_q  <= {{XLEN{1'b0}}, b};
        opnd_q <= a;
      end
    end else if (step) begin
      cnt_q <= cnt_q + 6'd1;
      if (mode) begin
        // Trial subtraction is non-negative exactly when the top bit of diff is clear.
        if (!diff[XLEN]) begin
          rem_q             <= diff[XLEN-1:0];
          acc_q[XLEN-1:0]   <= {acc_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q             <= part[XLEN-1:0];
          acc_q[XLEN-1:0]   <= {acc_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_q <= {sum, acc_q[XLEN-1:1]};
      end
    end
  end

  assign last = (cnt_q == 6'(ITER - 1));
  assign prod = acc_q;
  assign quot = acc_q[XLEN-1:0];
  assign rem  = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: FSM, sign handling and architectural HI/LO around the iterative datapath.
module hilo_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            divide_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  import muldiv_pkg::*;

  state_t state_q, state_d;

  logic              load, step, mode, last;
  logic              is_signed;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix;
  logic              div_q, neg_q, rneg_q;
  logic              hi_we, lo_we, done_d, dz_d;
  logic [XLEN-1:0]   hi_d, lo_d;

  // Operand magnitudes for signed ops, and final sign correction of the results.
  always_comb begin
    is_signed = (op == MULT_OP) || (op == DIV_OP);
    a_mag     = (is_signed && op1[XLEN-1]) ? -op1 : op1;
    b_mag     = (is_signed && op2[XLEN-1]) ? -op2 : op2;
    prod_fix  = neg_q  ? -prod : prod;
    quot_fix  = neg_q  ? -quot : quot;
    rem_fix   = rneg_q ? -rem  : rem;
  end

  // Next-state, datapath control and HI/LO write selection; flush overrides everything.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = (state_q == MUL) || (state_q == DIV);
    mode    = (state_q == DIV);
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_d    = hi;
    lo_d    = lo;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              MTHI_OP: begin
                hi_we = 1'b1;
                hi_d  = op1;
              end
              MTLO_OP: begin
                lo_we = 1'b1;
                lo_d  = op1;
              end
              MULT_OP, MULTU_OP: begin
                load    = 1'b1;
                mode    = 1'b0;
                state_d = MUL;
              end
              DIV_OP, DIVU_OP: begin
                mode = 1'b1;
                if (op2 == '0) begin
                  state_d = DONE;
                end else begin
                  load    = 1'b1;
                  state_d = DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (last) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b1;
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*XLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, status pulses, captured signs and the architectural HI/LO registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      done        <= 1'b0;
      divide_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done        <= done_d;
      divide_zero <= dz_d;
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
      if (load) begin
        div_q  <= mode;
        neg_q  <= is_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
        rneg_q <= is_signed & op1[XLEN-1];
      end
    end
  end

  assign busy = (state_q != IDLE);

  muldiv_iter #(
    .XLEN (XLEN),
    .ITER (ITER)
  ) u_iter (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (step),
    .mode  (mode),
    .a     (a_mag),
    .b     (b_mag),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem),
    .last  (last)
  );

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- It consumes the MULT/MULTU/DIV/DIVU/MTHI/MTLO operations that the single-cycle ALU stage issues, and it serves HI/LO to the MFHI/MFLO path.
- It sits beside the EX-stage ALU. It raises `busy` so the hazard unit stalls the pipeline while an iterative operation is in flight.

Parameters:
- XLEN, 32: operand and HI/LO width.
- ITER, 32: iterations per multiply or divide. Must equal XLEN.

Ports:
- clock, input, 1: single clock, rising-edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: issue request. Sampled only when state is IDLE.
- op, input, 5: operation, using the ALU control encoding (MULT_OP 5'b00110, MULTU_OP 5'b00111, DIV_OP 5'b01000, DIVU_OP 5'b01001, MTHI_OP 5'b10010, MTLO_OP 5'b10011).
- op1, input, 32: rs value (dividend, multiplicand, or MTHI/MTLO source).
- op2, input, 32: rt value (divisor or multiplier).
- flush, input, 1: abort the in-flight operation (pipeline flush).
- busy, output, 1: high while an iterative operation is in progress.
- done, output, 1: one-cycle pulse when the operation finishes.
- divide_zero, output, 1: pulsed together with `done` when the divisor is zero.
- hi, output, 32: HI register.
- lo, output, 32: LO register.

Behaviour:
- **Reset** (synchronous): hi=0, lo=0, busy=0, done=0, divide_zero=0, state=IDLE.
  - A reset mid-operation discards the operation; no `done` is produced.
- **States**: IDLE, MUL, DIV, FIX, DONE.
- **Accept rule**: start=1 in IDLE with a valid op is accepted at edge E0. In any other state `start` is ignored. Ops outside the six listed are ignored.
- **MTHI/MTLO**:
  - Single cycle: hi (or lo) <= op1 at E0.
  - State stays IDLE; no busy, no done.
- **MULT/MULTU**:
  - At E0, capture |op1| and |op2| (signed) or raw values (unsigned), plus the result sign = op1[31]^op2[31] (signed only). Go to MUL with the counter at 0.
  - MUL does one shift-add step per cycle over 32 edges, E1..E32, then goes to FIX.
  - At E33, FIX two's-complement-negates the 64-bit product if the sign bit is set. It writes {hi,lo}, pulses done=1 for that cycle, clears busy, and goes to IDLE.
  - busy is high for exactly 33 cycles, from after E0 through E33.
- **DIV/DIVU**:
  - If op2==0 at E0, go to DONE. At E1: done=1, divide_zero=1, busy=0, hi/lo unchanged.
  - Otherwise capture the magnitudes and do 32 restoring-division steps (E1..E32), then FIX at E33.
  - Quotient goes to lo and remainder goes to hi.
  - Signed division truncates toward zero: quotient sign = op1[31]^op2[31], remainder sign = op1[31].
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This wraps; no flag is raised.
- **Flush**:
  - Flush in any state goes to IDLE at the next edge; busy=0, no done, hi/lo retain their old values.
  - Flush and start in the same IDLE cycle: flush wins and start is ignored.
- **Timing**: hi/lo change only at the FIX edge or the MTHI/MTLO edge. No partial results are ever visible.
- **Width rules**:
  - Internal accumulator is 64 bits for multiply.
  - Partial remainder is 33 bits for divide.
  - Iteration counter is 6 bits; it terminates at the count of ITER.

Decomposition:
- **Package `muldiv_pkg`** holds:
  - XLEN;
  - the 5-bit op codes above (shared with the ALU decode);
  - the state enum {IDLE, MUL, DIV, FIX, DONE}.
- **Sub-module `muldiv_iter`** is the natural split. It is the datapath step: one shift-add or restore-subtract per cycle, selected by a mode bit. It holds the accumulator, operand and counter registers. The top level keeps the FSM, sign handling and HI/LO.

Test Plan:
1. MULT op1=0xFFFFFFFE, op2=3 -> busy high for 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat back-to-back with start in the cycle after done -> accepted.
3. DIV op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIV with op2=0 and prior hi=0xAAAA0000, lo=0x0000BBBB -> done and divide_zero high one cycle after E0; hi/lo unchanged; busy high 1 cycle.
5. MTHI op1=0x12345678 -> hi=0x12345678 at the next edge, done stays 0. Then MULT started and an MTLO issued during busy -> MTLO ignored, lo is the product only.
6. Start MULT, assert flush at iteration 10 -> IDLE next edge, busy=0, no done, hi/lo retain prior values. Repeat with reset at iteration 10 -> hi=lo=0.
